vector_fetch_ctrl: RTL and testbench
====================================

// Module: vector_fetch_ctrl
// PURPOSE
//   Exception/interrupt front end of the MIPS core; drives the vector table ROM address and consumes its data.
//   Prioritises a synchronous exception and IRQ_LINES level-sensitive interrupt lines, then drives the cause index to the ROM.
//   Latches the returned handler PC and offers it to the fetch stage with a req/ack handshake.
//   Masks further interrupts until the handler executes ERET.
// PARAMETERS
//   DATA_WIDTH  32  vector / PC width, matches vector table ROM data width
//   ADDR_WIDTH  4   vector table index width
//   IRQ_LINES   8   number of interrupt request lines
//   IRQ_BASE    8   table index of i_irq[0]; i_irq[n] -> index IRQ_BASE+n
//   Elaboration error if IRQ_BASE+IRQ_LINES > 2**ADDR_WIDTH.
// PORTS
//   i_clk        in   1           clock, all state on rising edge
//   i_rst        in   1           asynchronous, active-high reset
//   i_exc        in   1           synchronous exception strobe, one cycle
//   i_exc_code   in   ADDR_WIDTH  vector index for the exception, valid with i_exc
//   i_irq        in   IRQ_LINES   level-sensitive interrupt requests
//   i_ie         in   1           global interrupt enable (status register bit)
//   i_eret       in   1           handler return strobe, one cycle
//   i_ack        in   1           fetch stage accepted o_target_pc
//   i_vec_data   in   DATA_WIDTH  vector table ROM data (combinational from o_vec_addr)
//   o_vec_addr   out  ADDR_WIDTH  vector table ROM address, registered
//   o_req        out  1           o_target_pc/o_cause valid
//   o_target_pc  out  DATA_WIDTH  handler entry PC, registered
//   o_cause      out  ADDR_WIDTH  index of the event being serviced
//   o_busy       out  1           high from accept of event until ERET
// BEHAVIOUR
//   Reset (async, any state): state=IDLE, o_vec_addr=0, o_req=0, o_target_pc=0, o_cause=0, o_busy=0.
//   Any pending event is dropped.
//   States:
//   - IDLE:
//     - if i_exc: cause=i_exc_code -> FETCH.
//     - elif i_ie and |i_irq: cause=IRQ_BASE+n, where n is the lowest set bit -> FETCH.
//     - else stay.
//   - FETCH:
//     - o_vec_addr=cause and o_cause=cause are registered on entry.
//     - ROM settles within the cycle; at the next edge o_target_pc<=i_vec_data and o_req<=1 -> PRESENT.
//   - PRESENT:
//     - hold o_req, o_target_pc and o_cause stable until i_ack sampled high.
//     - then o_req<=0, o_busy stays 1 -> HANDLER.
//     - i_irq, i_exc and i_eret are ignored.
//   - HANDLER:
//     - i_irq ignored regardless of i_ie.
//     - i_exc: cause=i_exc_code -> FETCH (nested exception, o_busy stays 1).
//     - elif i_eret: o_busy<=0 -> IDLE.
//   o_busy: set on the IDLE->FETCH edge; cleared only on ERET or reset.
//   Latency: event sampled at edge N -> o_vec_addr valid after N+1 -> o_req high after N+2.
//   Minimum service time is 3 cycles with i_ack tied high.
//   Priorities:
//   - exception beats any IRQ in the same cycle.
//   - lower IRQ index beats higher.
//   - i_exc beats i_eret in the same cycle in HANDLER.
//   IRQ still asserted at ERET: IDLE is entered, and the IRQ is retaken on the following edge if i_ie=1.
//   Width: IRQ_BASE+n computed in ADDR_WIDTH bits; no wrap, guaranteed by the elaboration check.
//   o_vec_addr holds its last value outside FETCH (no ROM address toggling).
// TESTING
//   - Reset: assert i_rst mid-PRESENT -> o_req, o_busy, o_target_pc, o_vec_addr, o_cause all 0 immediately, without a clock edge.
//   - Single IRQ: i_ie=1, i_irq=8'h08, ROM[11]=32'h8000_0180 -> o_vec_addr=11 at N+1.
//     Then o_req=1, o_target_pc=32'h8000_0180, o_cause=11 at N+2.
//     i_ack -> o_req=0, o_busy=1.
//   - Priority: i_irq=8'h22 -> cause 9.
//     i_exc=1, i_exc_code=2 with i_irq=8'hFF in the same cycle -> cause 2.
//   - Masking:
//     - i_ie=0, i_irq=8'h01 for 10 cycles -> o_req stays 0.
//     - in HANDLER with i_ie=1, i_irq=8'h01 -> o_req stays 0.
//     - i_eret with IRQ still high -> IDLE, then o_req=1 two cycles later.
//   - Handshake hold: withhold i_ack 5 cycles while toggling i_irq and i_exc -> o_target_pc and o_cause unchanged, o_req held 1.
//   - Nested exception: in HANDLER, i_exc=1 with i_exc_code=4 and i_eret=1 together -> FETCH, o_cause=4, o_busy stays 1.

Source files
------------

// File: rtl/vector_fetch_ctrl.sv
// Exception/interrupt front end: picks the highest-priority event, reads its handler PC
// from the vector table ROM and offers it to fetch with a req/ack handshake until ERET.
module vector_fetch_ctrl #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned IRQ_LINES  = 8,
   parameter int unsigned IRQ_BASE   = 8
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_exc,
   input  logic [ADDR_WIDTH-1:0] i_exc_code,
   input  logic [IRQ_LINES-1:0]  i_irq,
   input  logic                  i_ie,
   input  logic                  i_eret,
   input  logic                  i_ack,
   input  logic [DATA_WIDTH-1:0] i_vec_data,
   output logic [ADDR_WIDTH-1:0] o_vec_addr,
   output logic                  o_req,
   output logic [DATA_WIDTH-1:0] o_target_pc,
   output logic [ADDR_WIDTH-1:0] o_cause,
   output logic                  o_busy
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] FETCH   = 2'd1;
   localparam logic [1:0] PRESENT = 2'd2;
   localparam logic [1:0] HANDLER = 2'd3;

   // IRQ indices must fit the vector table without wrapping
   if (IRQ_BASE + IRQ_LINES > 2**ADDR_WIDTH) begin : g_bad_irq_range
      $error("vector_fetch_ctrl: IRQ_BASE+IRQ_LINES exceeds vector table size");
   end

   logic [1:0]            state_q, state_d;
   logic [ADDR_WIDTH-1:0] vec_addr_d, cause_d;
   logic [DATA_WIDTH-1:0] pc_d;
   logic                  req_d, busy_d;
   logic                  irq_hit;
   logic [ADDR_WIDTH-1:0] irq_cause;

   // Lowest-numbered active line wins: scan downward so the last hit is the lowest
   always_comb begin
      irq_hit   = 1'b0;
      irq_cause = '0;
      for (int i = int'(IRQ_LINES) - 1; i >= 0; i--) begin
         if (i_irq[i]) begin
            irq_hit   = 1'b1;
            irq_cause = ADDR_WIDTH'(IRQ_BASE + 32'(i));
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      vec_addr_d = o_vec_addr;
      cause_d    = o_cause;
      pc_d       = o_target_pc;
      req_d      = o_req;
      busy_d     = o_busy;
      case (state_q)
         IDLE: begin
            if (i_exc) begin
               vec_addr_d = i_exc_code;
               cause_d    = i_exc_code;
               busy_d     = 1'b1;
               state_d    = FETCH;
            end else if (i_ie && irq_hit) begin
               vec_addr_d = irq_cause;
               cause_d    = irq_cause;
               busy_d     = 1'b1;
               state_d    = FETCH;
            end
         end
         FETCH: begin
            pc_d    = i_vec_data;
            req_d   = 1'b1;
            state_d = PRESENT;
         end
         PRESENT: begin
            if (i_ack) begin
               req_d   = 1'b0;
               state_d = HANDLER;
            end
         end
         HANDLER: begin
            // A nested exception outranks a simultaneous ERET
            if (i_exc) begin
               vec_addr_d = i_exc_code;
               cause_d    = i_exc_code;
               state_d    = FETCH;
            end else if (i_eret) begin
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q     <= IDLE;
         o_vec_addr  <= '0;
         o_cause     <= '0;
         o_target_pc <= '0;
         o_req       <= 1'b0;
         o_busy      <= 1'b0;
      end else begin
         state_q     <= state_d;
         o_vec_addr  <= vec_addr_d;
         o_cause     <= cause_d;
         o_target_pc <= pc_d;
         o_req       <= req_d;
         o_busy      <= busy_d;
      end
   end

endmodule

// File: tb/tb_vector_fetch_ctrl.sv
// Directed bench for vector_fetch_ctrl with a combinational vector ROM model.
module tb_vector_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        exc;
   logic [3:0]  exc_code;
   logic [7:0]  irq;
   logic        ie;
   logic        eret;
   logic        ack;
   logic [31:0] vec_data;
   logic [3:0]  vec_addr;
   logic        req;
   logic [31:0] target_pc;
   logic [3:0]  cause;
   logic        busy;

   int unsigned total = 0;
   int unsigned bad   = 0;

   always #5 clk = ~clk;

   vector_fetch_ctrl dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_exc       (exc),
      .i_exc_code  (exc_code),
      .i_irq       (irq),
      .i_ie        (ie),
      .i_eret      (eret),
      .i_ack       (ack),
      .i_vec_data  (vec_data),
      .o_vec_addr  (vec_addr),
      .o_req       (req),
      .o_target_pc (target_pc),
      .o_cause     (cause),
      .o_busy      (busy)
   );

   // ROM: entry 11 is the documented handler, others are 0x1000_0000 | index<<4
   function automatic logic [31:0] rom_f(input logic [3:0] a);
      if (a == 4'd11) return 32'h8000_0180;
      return 32'h1000_0000 | {24'h0, a, 4'h0};
   endfunction

   always_comb vec_data = rom_f(vec_addr);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; exc = 1'b0; exc_code = '0; irq = '0; ie = 1'b0; eret = 1'b0; ack = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_req", 32'(req), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_vec_addr", 32'(vec_addr), 32'd0);
      check("rst_pc", target_pc, 32'd0);
      check("rst_cause", 32'(cause), 32'd0);
      rst = 1'b0;

      // Interrupts disabled: no service
      irq = 8'h01;
      for (int i = 0; i < 10; i++) begin
         step();
         check("masked_ie_req", 32'(req), 32'd0);
      end
      check("masked_ie_busy", 32'(busy), 32'd0);

      // Single IRQ on line 3 -> index 11
      ie = 1'b1; irq = 8'h08;
      step();
      check("irq_vec_addr", 32'(vec_addr), 32'd11);
      check("irq_busy", 32'(busy), 32'd1);
      check("irq_req_early", 32'(req), 32'd0);
      irq = 8'h00;
      step();
      check("irq_req", 32'(req), 32'd1);
      check("irq_pc", target_pc, 32'h8000_0180);
      check("irq_cause", 32'(cause), 32'd11);
      ack = 1'b1;
      step();
      ack = 1'b0;
      check("irq_ack_req", 32'(req), 32'd0);
      check("irq_ack_busy", 32'(busy), 32'd1);

      // In HANDLER, IRQs are masked even with ie=1
      irq = 8'h01;
      for (int i = 0; i < 3; i++) begin
         step();
         check("handler_mask_req", 32'(req), 32'd0);
         check("handler_mask_busy", 32'(busy), 32'd1);
      end
      eret = 1'b1;
      step();
      eret = 1'b0;
      check("eret_busy", 32'(busy), 32'd0);
      step();
      check("retake_vec_addr", 32'(vec_addr), 32'd8);
      check("retake_busy", 32'(busy), 32'd1);
      step();
      check("retake_req", 32'(req), 32'd1);
      check("retake_pc", target_pc, 32'h1000_0080);

      // Withhold ack while inputs toggle: presented values stay put
      exc_code = 4'd3;
      for (int i = 0; i < 5; i++) begin
         irq = (i % 2 == 0) ? 8'hF0 : 8'h01;
         exc = (i % 2 == 0);
         step();
         check("hold_req", 32'(req), 32'd1);
         check("hold_pc", target_pc, 32'h1000_0080);
         check("hold_cause", 32'(cause), 32'd8);
      end
      irq = 8'h00; exc = 1'b0; ack = 1'b1;
      step();
      ack = 1'b0;
      check("hold_ack_req", 32'(req), 32'd0);
      eret = 1'b1;
      step();
      eret = 1'b0;
      check("eret2_busy", 32'(busy), 32'd0);

      // Lowest set line wins: 0x22 -> line 1 -> index 9
      irq = 8'h22;
      step();
      irq = 8'h00;
      check("prio_irq_cause", 32'(cause), 32'd9);
      step();
      check("prio_irq_pc", target_pc, 32'h1000_0090);
      ack = 1'b1; step(); ack = 1'b0;
      eret = 1'b1; step(); eret = 1'b0;

      // Exception beats all IRQs
      exc = 1'b1; exc_code = 4'd2; irq = 8'hFF;
      step();
      exc = 1'b0; irq = 8'h00;
      check("prio_exc_cause", 32'(cause), 32'd2);
      check("prio_exc_vec_addr", 32'(vec_addr), 32'd2);
      step();
      check("prio_exc_pc", target_pc, 32'h1000_0020);
      ack = 1'b1; step(); ack = 1'b0;

      // Nested exception outranks ERET in HANDLER
      exc = 1'b1; exc_code = 4'd4; eret = 1'b1;
      step();
      exc = 1'b0; eret = 1'b0;
      check("nest_cause", 32'(cause), 32'd4);
      check("nest_vec_addr", 32'(vec_addr), 32'd4);
      check("nest_busy", 32'(busy), 32'd1);
      check("nest_req_early", 32'(req), 32'd0);
      step();
      check("nest_req", 32'(req), 32'd1);
      check("nest_pc", target_pc, 32'h1000_0040);

      // Async reset mid-PRESENT clears outputs without a clock edge
      #2;
      rst = 1'b1;
      #1;
      check("arst_req", 32'(req), 32'd0);
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_pc", target_pc, 32'd0);
      check("arst_vec_addr", 32'(vec_addr), 32'd0);
      check("arst_cause", 32'(cause), 32'd0);
      step();
      rst = 1'b0;
      step();
      check("post_rst_req", 32'(req), 32'd0);
      check("post_rst_busy", 32'(busy), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
